mips_mc_ctrl: RTL and testbench

//  Multicycle control FSM for the MIPS core: sequences the shared datapath (reg file, ALU, single memory)

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/mips_alu_dec.sv | 21 ++
 rtl/mips_mc_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, functs, ALU codes,
// datapath select codes and the control FSM state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JAL, S_HALT
  } state_t;

  // True on the cycle an instruction leaves its last state back to FETCH.
  function automatic logic retires(input state_t st, input logic mem_ready);
    return (st == S_ALUWB) || (st == S_ADDIWB) || (st == S_MEMWB) ||
           (st == S_BRANCH) || (st == S_JAL) || ((st == S_MEMWR) && mem_ready);
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: ALU operation select plus a flag marking the funct as supported.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_SLT:  alu_control = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM driving the shared datapath selects and enables.
// Optional MC_PERF_EN adds retired-instruction and cycle counters.
module mips_mc_ctrl
  import mips_pkg::*;
`ifdef MC_PERF_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       illegal
`ifdef MC_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cyc_cnt
`endif
);

  state_t     state_reg;
  logic       illegal_reg;
  logic [2:0] dec_alu;
  logic       dec_legal;
  logic       decode_bad;

  mips_alu_dec u_alu_dec (
    .funct       (funct),
    .alu_control (dec_alu),
    .legal       (dec_legal)
  );

  always_comb begin
    decode_bad = 1'b0;
    case (op)
      OP_RTYPE:                       decode_bad = !dec_legal;
      OP_ADDI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_JAL:         decode_bad = 1'b0;
      default:                        decode_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH:  if (mem_ready) state_reg <= S_DECODE;
        S_DECODE: begin
          if (decode_bad) begin
            state_reg   <= S_HALT;
            illegal_reg <= 1'b1;
          end else begin
            case (op)
              OP_RTYPE:       state_reg <= S_EXEC;
              OP_ADDI:        state_reg <= S_ADDIEX;
              OP_LW, OP_SW:   state_reg <= S_MEMADR;
              OP_BEQ, OP_BNE: state_reg <= S_BRANCH;
              default:        state_reg <= S_JAL;
            endcase
          end
        end
        S_EXEC:   state_reg <= S_ALUWB;
        S_ADDIEX: state_reg <= S_ADDIWB;
        S_MEMADR: state_reg <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state_reg <= S_MEMWB;
        S_MEMWR:  if (mem_ready) state_reg <= S_FETCH;
        S_HALT:   state_reg <= S_HALT;
        default:  state_reg <= S_FETCH;
      endcase
    end
  end

  // Outputs are held at their idle values while rst_n is low, even though the state is FETCH.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RT;
    alu_control = ALU_ADD;
    reg_write   = 1'b0;
    reg_dst     = DST_RT;
    mem_to_reg  = WB_ALUOUT;
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          pc_src    = PC_ALU;
        end
        S_DECODE: alu_src_b = SRCB_IMM_SH2;
        S_EXEC: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRCB_RT;
          alu_control = dec_alu;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = DST_RD;
          mem_to_reg = WB_ALUOUT;
        end
        S_ADDIEX, S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
          reg_dst   = DST_RT;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          reg_dst    = DST_RT;
          mem_to_reg = WB_MDR;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRCB_RT;
          alu_control = ALU_SUB;
          pc_src      = PC_ALUOUT;
          pc_write    = zero ^ (op == OP_BNE);
        end
        S_JAL: begin
          pc_src     = PC_JUMP;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = DST_R31;
          mem_to_reg = WB_PC;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_reg;

`ifdef MC_PERF_EN
  logic [CNT_W-1:0] instr_cnt_reg;
  logic [CNT_W-1:0] cyc_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_reg <= '0;
      cyc_cnt_reg   <= '0;
    end else if (state_reg != S_HALT) begin
      cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
      if (retires(state_reg, mem_ready)) instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
    end
  end

  assign instr_cnt = instr_cnt_reg;
  assign cyc_cnt   = cyc_cnt_reg;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: table of per-cycle vectors through a scoreboard,
// plus hand-written reset, illegal-opcode and (with MC_PERF_EN) counter sequences.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;
  } outs_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  localparam logic [5:0] R = 6'h00, ADDI = 6'h08, LW = 6'h23, SW = 6'h2b;
  localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, JAL = 6'h03, BAD = 6'h3f;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_SLT = 6'h2a, F_SLL = 6'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic       alu_src_a, reg_write, illegal;
  logic [2:0] alu_control;
`ifdef MC_PERF_EN
  logic [31:0] instr_cnt, cyc_cnt;
`endif

  mips_mc_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .illegal     (illegal)
`ifdef MC_PERF_EN
    ,
    .instr_cnt   (instr_cnt),
    .cyc_cnt     (cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  outs_t exp_q[$];
  string name_q[$];
  vec_t  vecs[$];
  int    checks = 0;
  int    errors = 0;

  function automatic outs_t o_base();
    outs_t o = '0;
    o.alu_control = 3'b010;
    return o;
  endfunction

  function automatic outs_t o_fetch(input logic r);
    outs_t o = o_base();
    o.mem_req = 1'b1; o.alu_src_b = 2'b01; o.ir_write = r; o.pc_write = r;
    return o;
  endfunction

  function automatic outs_t o_decode();
    outs_t o = o_base();
    o.alu_src_b = 2'b11;
    return o;
  endfunction

  function automatic outs_t o_exec(input logic [2:0] a);
    outs_t o = o_base();
    o.alu_src_a = 1'b1; o.alu_control = a;
    return o;
  endfunction

  function automatic outs_t o_wb(input logic [1:0] dst, input logic [1:0] m2r);
    outs_t o = o_base();
    o.reg_write = 1'b1; o.reg_dst = dst; o.mem_to_reg = m2r;
    return o;
  endfunction

  function automatic outs_t o_imm();
    outs_t o = o_base();
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
    return o;
  endfunction

  function automatic outs_t o_mem(input logic wr);
    outs_t o = o_base();
    o.mem_req = 1'b1; o.iord = 1'b1; o.mem_write = wr;
    return o;
  endfunction

  function automatic outs_t o_branch(input logic taken);
    outs_t o = o_base();
    o.alu_src_a = 1'b1; o.alu_control = 3'b110; o.pc_src = 2'b01; o.pc_write = taken;
    return o;
  endfunction

  function automatic outs_t o_jal();
    outs_t o = o_base();
    o.pc_src = 2'b10; o.pc_write = 1'b1; o.reg_write = 1'b1;
    o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
    return o;
  endfunction

  function automatic outs_t o_halt();
    outs_t o = o_base();
    o.illegal = 1'b1;
    return o;
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a.mem_req = mem_req; a.mem_write = mem_write; a.iord = iord;
    a.ir_write = ir_write; a.pc_write = pc_write; a.pc_src = pc_src;
    a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b; a.alu_control = alu_control;
    a.reg_write = reg_write; a.reg_dst = reg_dst; a.mem_to_reg = mem_to_reg;
    a.illegal = illegal;
    return a;
  endfunction

  task automatic add_v(input string nm, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r, input outs_t e);
    vec_t v;
    v.name = nm; v.op = o; v.funct = f; v.zero = z; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check_pop();
    outs_t e, a;
    string nm;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow: got empty queue required one entry");
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = actual();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %05h required %05h", nm, a, e);
      end else
        $display("ok   %-20s outs=%05h", nm, a);
    end
  endtask

  // Entered at posedge+1: drive one cycle's inputs, check at negedge, advance to next posedge+1.
  task automatic step(input string nm, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic r, input outs_t e);
    op = o; funct = f; zero = z; mem_ready = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string nm, input outs_t e);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    check_pop();
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end else
      $display("ok   %-20s value=%0d", nm, got);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    check_now("reset.assert", o_base());
    @(posedge clk);
    #1;
    check_now("reset.hold", o_base());
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset.initial", o_base());
    rst_n = 1'b1;

    add_v("add.fetch_wait", R, F_ADD, 0, 0, o_fetch(0));
    add_v("add.fetch",      R, F_ADD, 0, 1, o_fetch(1));
    add_v("add.decode",     R, F_ADD, 0, 1, o_decode());
    add_v("add.exec",       R, F_ADD, 0, 1, o_exec(3'b010));
    add_v("add.wb",         R, F_ADD, 1, 1, o_wb(2'b01, 2'b00));
    add_v("sub.fetch",      R, F_SUB, 0, 1, o_fetch(1));
    add_v("sub.decode",     R, F_SUB, 0, 0, o_decode());
    add_v("sub.exec",       R, F_SUB, 0, 0, o_exec(3'b110));
    add_v("sub.wb",         R, F_SUB, 0, 0, o_wb(2'b01, 2'b00));
    add_v("slt.fetch",      R, F_SLT, 0, 1, o_fetch(1));
    add_v("slt.decode",     R, F_SLT, 0, 1, o_decode());
    add_v("slt.exec",       R, F_SLT, 1, 1, o_exec(3'b111));
    add_v("slt.wb",         R, F_SLT, 0, 1, o_wb(2'b01, 2'b00));
    add_v("addi.fetch",     ADDI, 6'h15, 0, 1, o_fetch(1));
    add_v("addi.decode",    ADDI, 6'h15, 0, 1, o_decode());
    add_v("addi.ex",        ADDI, 6'h15, 0, 1, o_imm());
    add_v("addi.wb",        ADDI, 6'h15, 0, 1, o_wb(2'b00, 2'b00));
    add_v("lw.fetch",       LW, 6'h04, 0, 1, o_fetch(1));
    add_v("lw.decode",      LW, 6'h04, 0, 1, o_decode());
    add_v("lw.memadr",      LW, 6'h04, 0, 1, o_imm());
    add_v("lw.memrd_w0",    LW, 6'h04, 0, 0, o_mem(0));
    add_v("lw.memrd_w1",    LW, 6'h04, 1, 0, o_mem(0));
    add_v("lw.memrd_w2",    LW, 6'h04, 0, 0, o_mem(0));
    add_v("lw.memrd_done",  LW, 6'h04, 0, 1, o_mem(0));
    add_v("lw.memwb",       LW, 6'h04, 0, 0, o_wb(2'b00, 2'b01));
    add_v("sw.fetch",       SW, 6'h08, 0, 1, o_fetch(1));
    add_v("sw.decode",      SW, 6'h08, 0, 1, o_decode());
    add_v("sw.memadr",      SW, 6'h08, 0, 0, o_imm());
    add_v("sw.memwr_wait",  SW, 6'h08, 0, 0, o_mem(1));
    add_v("sw.memwr_done",  SW, 6'h08, 0, 1, o_mem(1));
    add_v("beq1.fetch",     BEQ, 6'h00, 0, 1, o_fetch(1));
    add_v("beq1.decode",    BEQ, 6'h00, 0, 1, o_decode());
    add_v("beq1.branch",    BEQ, 6'h00, 1, 1, o_branch(1));
    add_v("beq0.fetch",     BEQ, 6'h00, 0, 1, o_fetch(1));
    add_v("beq0.decode",    BEQ, 6'h00, 0, 1, o_decode());
    add_v("beq0.branch",    BEQ, 6'h00, 0, 1, o_branch(0));
    add_v("bne1.fetch",     BNE, 6'h00, 0, 1, o_fetch(1));
    add_v("bne1.decode",    BNE, 6'h00, 0, 1, o_decode());
    add_v("bne1.branch",    BNE, 6'h00, 1, 1, o_branch(0));
    add_v("bne0.fetch",     BNE, 6'h00, 0, 1, o_fetch(1));
    add_v("bne0.decode",    BNE, 6'h00, 0, 1, o_decode());
    add_v("bne0.branch",    BNE, 6'h00, 0, 1, o_branch(1));
    add_v("jal.fetch",      JAL, 6'h3c, 0, 1, o_fetch(1));
    add_v("jal.decode",     JAL, 6'h3c, 0, 1, o_decode());
    add_v("jal.jump",       JAL, 6'h3c, 0, 1, o_jal());
    add_v("end.fetch_wait", R, F_ADD, 0, 0, o_fetch(0));

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].rdy, vecs[i].exp);

    // Unsupported opcode: terminal HALT with illegal set, no writes whatever the inputs.
    step("bad.fetch",  BAD, 6'h00, 0, 1, o_fetch(1));
    step("bad.decode", BAD, 6'h00, 0, 1, o_decode());
    for (int i = 0; i < 20; i++)
      step("bad.halt", 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o_halt());

    // Reset clears illegal; then an unsupported R-type funct also halts.
    do_reset();
    step("sll.fetch",  R, F_SLL, 0, 1, o_fetch(1));
    step("sll.decode", R, F_SLL, 0, 1, o_decode());
    step("sll.halt0",  R, F_SLL, 1, 1, o_halt());
    step("sll.halt1",  BEQ, F_SLL, 1, 1, o_halt());

    // Reset asserted mid-MEMRD aborts the load; the next instruction restarts at FETCH.
    do_reset();
    step("lwr.fetch",  LW, 6'h00, 0, 1, o_fetch(1));
    step("lwr.decode", LW, 6'h00, 0, 1, o_decode());
    step("lwr.memadr", LW, 6'h00, 0, 1, o_imm());
    step("lwr.memrd",  LW, 6'h00, 0, 0, o_mem(0));
    mem_ready = 1'b1;
    do_reset();
    step("lwr.after_fetch",  R, F_ADD, 0, 0, o_fetch(0));
    step("lwr.after_fetch1", R, F_ADD, 0, 1, o_fetch(1));
    step("lwr.after_decode", R, F_ADD, 0, 1, o_decode());

`ifdef MC_PERF_EN
    do_reset();
    check_val("perf.reset_cyc", cyc_cnt, 0);
    for (int n = 0; n < 3; n++) begin
      step("perf.addi_fetch",  ADDI, 6'h01, 0, 1, o_fetch(1));
      step("perf.addi_decode", ADDI, 6'h01, 0, 1, o_decode());
      step("perf.addi_ex",     ADDI, 6'h01, 0, 1, o_imm());
      step("perf.addi_wb",     ADDI, 6'h01, 0, 1, o_wb(2'b00, 2'b00));
    end
    check_val("perf.instr_after3", instr_cnt, 3);
    step("perf.bad_fetch",  BAD, 6'h00, 0, 1, o_fetch(1));
    step("perf.bad_decode", BAD, 6'h00, 0, 1, o_decode());
    check_val("perf.instr_halt", instr_cnt, 3);
    check_val("perf.cyc_halt",   cyc_cnt, 14);
    repeat (5) step("perf.halt", ADDI, 6'h00, 0, 1, o_halt());
    check_val("perf.cyc_frozen",   cyc_cnt, 14);
    check_val("perf.instr_frozen", instr_cnt, 3);
`endif

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
